// File: rtl/mux_scan_controller.sv
// mux_scan_controller
// Walks the select lines of a 4-to-1 mux through all four inputs. At each input it holds the
// selects stable for SETTLE_CYCLES cycles, samples the mux output, and finally presents the
// four captured bits as one parallel word with a one-cycle done pulse.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   scan request, honoured only while idle
//   mux_in     in   output bit of the 4-to-1 mux
//   sel        out  [1:0] mux selects (sel[1] outer pair select, sel[0] inner select)
//   busy       out  high whenever a scan is in progress or finishing
//   done       out  one-cycle pulse when a scan completes
//   word       out  [3:0] captured data, word[i] sampled while sel == i
//   word_valid out  word holds a completed scan
module mux_scan_controller #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mux_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] word,
  output logic       word_valid
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [7:0] Reload = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] word_q, word_d;
  logic       word_valid_q, word_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    sel_d        = sel_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d        = 2'd0;
          cnt_d        = Reload;
          word_valid_d = 1'b0;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSample: begin
        shadow_d[sel_q] = mux_in;
        if (sel_q == 2'd3) begin
          // Publish the whole shadow, including the bit captured this cycle.
          word_d       = shadow_d;
          word_valid_d = 1'b1;
          state_d      = StDone;
        end else begin
          // sel only moves on entry to SETTLE, so every sample sees a full settle window.
          sel_d   = sel_q + 2'd1;
          cnt_d   = Reload;
          state_d = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      shadow_q     <= 4'd0;
      sel_q        <= 2'd0;
      word_q       <= 4'd0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller. Two instances: one with the default settle time
// (optionally driven through a delayed mux model) and one with SETTLE_CYCLES = 1.
module tb_mux_scan_controller;

  logic       clock;
  logic       reset;
  logic       start, start1;
  logic       mux_in, mux_in1;
  logic [1:0] sel, sel1;
  logic       busy, busy1;
  logic       done, done1;
  logic [3:0] word, word1;
  logic       word_valid, word_valid1;

  logic [3:0] ins;
  logic       delayed;
  logic [1:0] d1, d2, d3;

  int n_cmp;
  int n_err;

  mux_scan_controller #(.SETTLE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mux_in     (mux_in),
    .sel        (sel),
    .busy       (busy),
    .done       (done),
    .word       (word),
    .word_valid (word_valid)
  );

  mux_scan_controller #(.SETTLE_CYCLES(1)) dut1 (
    .clock      (clock),
    .reset      (reset),
    .start      (start1),
    .mux_in     (mux_in1),
    .sel        (sel1),
    .busy       (busy1),
    .done       (done1),
    .word       (word1),
    .word_valid (word_valid1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mux model: optional 3-cycle lag of the output behind any sel change.
  always @(posedge clock) begin
    d1 <= sel;
    d2 <= d1;
    d3 <= d2;
  end
  assign mux_in  = delayed ? ins[d3] : ins[sel];
  assign mux_in1 = ins[sel1];

  wire [8:0] obs0 = {sel, busy, done, word_valid, word};
  wire [8:0] obs1 = {sel1, busy1, done1, word_valid1, word1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected {sel, busy, done, word_valid, word} in the cycle after edge E0+k.
  function automatic logic [8:0] exp_vec(int k, int s, logic [3:0] res, logic [3:0] prev);
    int         last;
    logic [1:0] e_sel;
    last  = 4 * (s + 1);
    e_sel = (k >= 3 * (s + 1)) ? 2'd3 : 2'(k / (s + 1));
    return {e_sel, (k <= last), (k == last), (k >= last), ((k >= last) ? res : prev)};
  endfunction

  // Pulse start for one instance and check every cycle through the first idle cycle.
  task automatic run_scan(input int which, input int s, input logic [3:0] res,
                          input logic [3:0] prev);
    int last;
    last = 4 * (s + 1);
    if (which == 0) start = 1'b1;
    else            start1 = 1'b1;
    tick();
    start  = 1'b0;
    start1 = 1'b0;
    for (int k = 0; k <= last + 1; k++) begin
      check($sformatf("scan%0d k=%0d", which, k), (which == 0) ? obs0 : obs1,
            exp_vec(k, s, res, prev));
      if (k <= last) tick();
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    start1  = 1'b0;
    ins     = 4'b0000;
    delayed = 1'b0;

    // Reset then idle.
    repeat (2) tick();
    check("reset", obs0, 9'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle i=%0d", i), obs0, 9'd0);
      check($sformatf("idle1 i=%0d", i), obs1, 9'd0);
    end

    // Basic scan.
    ins = 4'b1010;
    run_scan(0, 4, 4'b1010, 4'b0000);

    // Settle guarantee through a lagging mux, then the shortest settle time.
    delayed = 1'b1;
    ins     = 4'b0110;
    run_scan(0, 4, 4'b0110, 4'b1010);
    delayed = 1'b0;
    ins     = 4'b1001;
    run_scan(1, 1, 4'b1001, 4'b0000);

    // start held high: back-to-back scans every 22 cycles; inputs change mid second scan
    // after input 0 was already sampled, so the second word is 1110.
    ins   = 4'b1010;
    start = 1'b1;
    tick();
    for (int k = 0; k <= 65; k++) begin
      int         kk;
      int         sc;
      logic [3:0] res;
      logic [3:0] prv;
      kk  = k % 22;
      sc  = k / 22;
      res = (sc == 0) ? 4'b1010 : (sc == 1) ? 4'b1110 : 4'b1111;
      prv = (sc == 0) ? 4'b0110 : (sc == 1) ? 4'b1010 : 4'b1110;
      check($sformatf("held k=%0d", k), obs0, exp_vec(kk, 4, res, prv));
      if (k == 30) ins = 4'b1111;
      if (k == 65) start = 1'b0;
      else         tick();
    end

    // Reset mid-scan while sel == 2 with a valid word 1010 from the previous scan.
    ins = 4'b1010;
    run_scan(0, 4, 4'b1010, 4'b1111);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check($sformatf("pre_rst k=%0d", k), obs0, exp_vec(k, 4, 4'b1010, 4'b1010));
      if (k < 10) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid", obs0, 9'd0);
    for (int i = 0; i < 25; i++) begin
      tick();
      check($sformatf("post_rst i=%0d", i), obs0, 9'd0);
    end
    ins = 4'b0101;
    run_scan(0, 4, 4'b0101, 4'b0000);

    // Reset and start together: reset wins, a start one cycle later is accepted.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start", obs0, 9'd0);
    ins = 4'b0011;
    run_scan(0, 4, 4'b0011, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_controller.md
# mux_scan_controller

Sequencer that drives the two select lines of the switch-board 4-to-1 mux stage and captures its single-bit output. On a start pulse it walks the selects through all four inputs, waits a programmable settle time at each, and samples the mux output. It then presents the four sampled bits as one parallel word with a done pulse. It sits both upstream of the mux (it feeds its selects) and downstream of it (it consumes the mux output), and replaces hand-set select switches with a timed scan.

## Interface
- SETTLE_CYCLES, default 4: cycles the select lines are held stable before each sample. Legal values are 1..255.
- clock  input  1  system clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a scan. Sampled only in IDLE.
- mux_in  input  1  output bit of the 4-to-1 mux.
- sel  output  2  selects driven to the mux. sel[1] is the outer (pair) select; sel[0] is the inner select, shared by both first-level 2-to-1 muxes. The selected input index equals sel.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a scan completes.
- word  output  4  captured data; word[i] is the mux output sampled while sel == i.
- word_valid  output  1  word holds the result of a completed scan.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Internal signals: a settle down-counter of 8 bits and a 4-bit shadow register.
- IDLE with start = 1:
  - set sel to 0
  - load the counter with SETTLE_CYCLES-1
  - clear word_valid
  - go to SETTLE
- IDLE with start = 0: stay in IDLE.
- SETTLE:
  - if counter == 0, go to SAMPLE
  - otherwise decrement the counter
  - sel does not change
- SAMPLE: write mux_in into shadow[sel].
  - If sel == 3: copy the shadow register (including the bit just sampled) into word, set word_valid, go to DONE.
  - Otherwise: increment sel, reload the counter with SETTLE_CYCLES-1, go to SETTLE.
- DONE: done = 1 for this cycle only, then go to IDLE. sel stays at 3 until the next accepted start.
- start outside IDLE is ignored. This includes start in the DONE cycle; it is neither queued nor remembered.
- word changes only when a scan completes, so it never shows a partial scan. word_valid stays high until the next start is accepted or reset is asserted.
- The shadow register never drives an output.
- sel changes only on the transition into SETTLE. This guarantees at least SETTLE_CYCLES stable cycles before each sample.

## Timing
- Reset values:
  - state IDLE
  - sel = 2'b00
  - busy = 0
  - done = 0
  - word = 4'b0000
  - word_valid = 0
  - counter = 0
  - shadow = 0
- Reset mid-scan: at the next edge the block returns to the reset values. No done pulse is produced, and the previous word is discarded (cleared to 0).
- Reset and start high in the same cycle: reset wins. The block is in IDLE afterwards, and start must be reasserted.
- Let E0 be the edge at which start is accepted.
  - Each input occupies SETTLE_CYCLES cycles of SETTLE plus 1 cycle of SAMPLE.
  - Input i is sampled at edge E0 + (i+1)·(SETTLE_CYCLES+1).
  - word, word_valid and done become visible in the cycle after edge E0 + 4·(SETTLE_CYCLES+1). With the default this is edge E0+20.
  - busy falls at edge E0 + 4·(SETTLE_CYCLES+1) + 1.
- Minimum gap between scans: start may be accepted one cycle after done.
- SETTLE_CYCLES = 1: SETTLE lasts exactly one cycle (counter loaded with 0).
- All outputs are registered. There is no combinational path from start or mux_in to any output.

## Test plan
- Reset then idle: assert reset for 2 cycles and hold start = 0 for 10 cycles. Required: sel = 0, busy = 0, done = 0, word = 0, word_valid = 0 throughout.
- Basic scan: bench models the mux with inputs 4'b1010 (input i = bit i) and SETTLE_CYCLES = 4. Pulse start.
  - sel steps 0→1→2→3; each value is held 5 cycles.
  - done pulses exactly once, 20 cycles after the accept edge.
  - word = 4'b1010 and word_valid = 1 from then on.
  - busy falls one cycle later.
- Settle guarantee: mux inputs 4'b0110, but the mux model delays its output by SETTLE_CYCLES-1 = 3 cycles after any sel change. Required: word = 4'b0110. Then set SETTLE_CYCLES = 1 with a zero-delay mux: done arrives 8 cycles after accept.
- Start ignored while busy: hold start high continuously. Scans run back to back; each new scan is accepted in the IDLE cycle after done. done pulses every 22 cycles (default settle). Change the mux inputs to 4'b1111 mid-scan: word updates only at done, and word_valid drops on each accept.
- Reset mid-scan: assert reset while sel = 2 after a completed scan left word = 4'b1010. Required after the next edge: all outputs at reset values, no done pulse, word = 0. A fresh start then completes normally.
- Simultaneous reset and start: block stays in IDLE with busy = 0. A start pulse one cycle later is accepted.
